// File: rtl/instruction_fetch_if.sv
// Instruction memory fetch channel: a request with an address, answered by an ack
// carrying the instruction word on the same edge.
interface instruction_fetch_if #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 15
);
   logic               req;
   logic [PC_W-1:0]    addr;
   logic               ack;
   logic [INSTR_W-1:0] data;

   modport master (output req, addr, input ack, data);
   modport slave  (input req, addr, output ack, data);
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, fetches words over the req/ack channel and presents
// opcode/k8 to the control unit until execute reports completion.
module instruction_fetch #(
   parameter int         PC_W     = 8,
   parameter int         INSTR_W  = 15,
   parameter logic [6:0] NOP_OPC  = 7'h7F,
   parameter logic [6:0] HALT_OPC = 7'h7E
) (
   input  logic                clk,
   input  logic                rst_n,
   instruction_fetch_if.master imem,
   input  logic                exec_done,
   input  logic                l_pc,
   input  logic [PC_W-1:0]     jump_addr,
   output logic [6:0]          opcode,
   output logic [7:0]          k8,
   output logic                instr_valid,
   output logic [PC_W-1:0]     pc,
   output logic                halted
);

   typedef enum logic [1:0] {FETCH, ISSUE, HALT} state_t;

   state_t             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic               req_q, req_d;
   logic               valid_q, valid_d;
   logic               halted_q, halted_d;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      req_d    = req_q;
      valid_d  = valid_q;
      halted_d = halted_q;
      case (state_q)
         FETCH: begin
            req_d = 1'b1;
            // An ack only counts once our request is actually on the bus.
            if (req_q && imem.ack) begin
               ir_d  = imem.data;
               req_d = 1'b0;
               if (imem.data[INSTR_W-1 -: 7] == HALT_OPC) begin
                  state_d  = HALT;
                  halted_d = 1'b1;
               end else begin
                  state_d = ISSUE;
                  valid_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            if (exec_done) begin
               pc_d    = l_pc ? jump_addr : pc_q + PC_W'(1);
               valid_d = 1'b0;
               req_d   = 1'b1;
               state_d = FETCH;
            end
         end
         HALT: begin
            req_d   = 1'b0;
            valid_d = 1'b0;
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= FETCH;
         pc_q     <= '0;
         ir_q     <= '0;
         req_q    <= 1'b0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         req_q    <= req_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
      end
   end

   // Outside ISSUE the control unit sees an unmapped opcode and a zero literal.
   assign opcode      = valid_q ? ir_q[INSTR_W-1 -: 7] : NOP_OPC;
   assign k8          = valid_q ? ir_q[7:0] : 8'h00;
   assign instr_valid = valid_q;
   assign pc          = pc_q;
   assign halted      = halted_q;
   assign imem.req    = req_q;
   assign imem.addr   = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboarded bench for instruction_fetch: stimulus queues expected fetch
// addresses and issued instructions, a negedge monitor pops and compares them.
module tb_instruction_fetch;

   typedef struct packed {
      logic [6:0] op;
      logic [7:0] k;
      logic [7:0] pc;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       exec_done;
   logic       l_pc;
   logic [7:0] jump_addr;
   logic [6:0] opcode;
   logic [7:0] k8;
   logic       instr_valid;
   logic [7:0] pc;
   logic       halted;

   instruction_fetch_if #(.PC_W(8), .INSTR_W(15)) imem();

   instruction_fetch #(.PC_W(8), .INSTR_W(15)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem        (imem),
      .exec_done   (exec_done),
      .l_pc        (l_pc),
      .jump_addr   (jump_addr),
      .opcode      (opcode),
      .k8          (k8),
      .instr_valid (instr_valid),
      .pc          (pc),
      .halted      (halted)
   );

   int          n_chk = 0;
   int          n_fail = 0;
   exp_t        iq[$];
   logic [7:0]  aq[$];
   logic [14:0] mem [256];
   int          lat = 1;
   logic        spur = 1'b0;
   int          mcnt = 0;
   logic        prev_req = 1'b0;
   logic        prev_valid = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_pc"},     32'(pc),          32'h00);
      chk({tag, "_req"},    32'(imem.req),    32'h0);
      chk({tag, "_valid"},  32'(instr_valid), 32'h0);
      chk({tag, "_opcode"}, 32'(opcode),      32'h7F);
      chk({tag, "_k8"},     32'(k8),          32'h00);
      chk({tag, "_halted"}, 32'(halted),      32'h0);
   endtask

   task automatic push_instr(input logic [14:0] w, input logic [7:0] p);
      exp_t e;
      e.op = w[14:8];
      e.k  = w[7:0];
      e.pc = p;
      iq.push_back(e);
   endtask

   task automatic wait_valid(input string name);
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (instr_valid) seen = 1;
      end
      if (!seen) chk({name, "_timeout"}, 32'h0, 32'h1);
   endtask

   // Called at a negedge; returns just after the sampling edge.
   task automatic do_exec(input logic l, input logic [7:0] ja);
      exec_done = 1'b1;
      l_pc      = l;
      jump_addr = ja;
      @(posedge clk);
      #1;
      exec_done = 1'b0;
      l_pc      = 1'b0;
   endtask

   // Memory model: acks on the lat-th request cycle; spur forces an ack.
   always @(negedge clk) begin
      if (spur) begin
         imem.ack  = 1'b1;
         imem.data = 15'h0777;
      end else if (!rst_n || !imem.req) begin
         imem.ack = 1'b0;
         mcnt     = 0;
      end else begin
         mcnt++;
         if (mcnt >= lat) begin
            imem.ack  = 1'b1;
            imem.data = mem[imem.addr];
            mcnt      = 0;
         end else begin
            imem.ack = 1'b0;
         end
      end
   end

   // Monitor: every new request and every newly presented instruction is scored.
   always @(negedge clk) begin
      if (rst_n) begin
         if (imem.req && !prev_req) begin
            if (aq.size() == 0) chk("fetch_unexpected", 32'(imem.addr), 32'hFFFF);
            else chk("fetch_addr", 32'(imem.addr), 32'(aq.pop_front()));
         end
         if (instr_valid && !prev_valid) begin
            if (iq.size() == 0) chk("issue_unexpected", {17'h0, opcode, k8}, 32'hFFFF);
            else begin
               exp_t e;
               e = iq.pop_front();
               chk("issue_opcode", 32'(opcode), 32'(e.op));
               chk("issue_k8",     32'(k8),     32'(e.k));
               chk("issue_pc",     32'(pc),     32'(e.pc));
            end
         end
      end
      prev_req   = imem.req;
      prev_valid = instr_valid;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      bit done;
      for (int i = 0; i < 256; i++) mem[i] = 15'h0000;
      mem[8'h00] = 15'h0215;
      mem[8'h01] = 15'h0303;
      mem[8'h03] = 15'h7E00;
      mem[8'h05] = 15'h0A0B;
      mem[8'h06] = 15'h0106;
      mem[8'h40] = 15'h1122;
      mem[8'hFF] = 15'h03FF;
      rst_n = 1'b0;
      exec_done = 1'b0;
      l_pc = 1'b0;
      jump_addr = 8'h00;
      repeat (3) @(negedge clk);
      chk_reset("rst");

      // Zero-latency memory: instruction live on the second edge after release.
      aq.push_back(8'h00); push_instr(15'h0215, 8'h00);
      rst_n = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("c2_valid",  32'(instr_valid), 32'h1);
      chk("c2_opcode", 32'(opcode),      32'h02);
      chk("c2_k8",     32'(k8),          32'h15);
      wait_valid("i0");
      aq.push_back(8'h01); push_instr(15'h0303, 8'h01);
      do_exec(1'b0, 8'h00);
      chk("seq_addr", 32'(imem.addr), 32'h01);
      wait_valid("i1");

      // Three-cycle memory latency on the jump to 5.
      lat = 3;
      aq.push_back(8'h05); push_instr(15'h0A0B, 8'h05);
      do_exec(1'b1, 8'h05);
      cnt = 0;
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (instr_valid) done = 1;
         else begin
            if (imem.req) cnt++;
            chk("wait_opcode", 32'(opcode),    32'h7F);
            chk("wait_addr",   32'(imem.addr), 32'h05);
         end
      end
      chk("req_cycles", 32'(cnt), 32'd3);
      lat = 1;

      aq.push_back(8'h40); push_instr(15'h1122, 8'h40);
      do_exec(1'b1, 8'h40);
      chk("jump_pc",   32'(pc),        32'h40);
      chk("jump_addr", 32'(imem.addr), 32'h40);
      wait_valid("i40");
      aq.push_back(8'h05); push_instr(15'h0A0B, 8'h05);
      do_exec(1'b1, 8'h05);
      wait_valid("i5b");
      aq.push_back(8'h06); push_instr(15'h0106, 8'h06);
      do_exec(1'b0, 8'h40);
      chk("seq_pc6", 32'(pc), 32'h06);
      wait_valid("i6");
      aq.push_back(8'hFF); push_instr(15'h03FF, 8'hFF);
      do_exec(1'b1, 8'hFF);
      wait_valid("iff");
      aq.push_back(8'h00); push_instr(15'h0215, 8'h00);
      do_exec(1'b0, 8'h12);
      chk("wrap_pc", 32'(pc), 32'h00);
      wait_valid("iwrap");
      // Jump to the current pc refetches the same word.
      aq.push_back(8'h00); push_instr(15'h0215, 8'h00);
      do_exec(1'b1, 8'h00);
      chk("self_pc", 32'(pc), 32'h00);
      wait_valid("iself");

      // HALT word at address 3.
      aq.push_back(8'h03);
      do_exec(1'b1, 8'h03);
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (halted) done = 1;
      end
      chk("halt_halted", 32'(halted),      32'h1);
      chk("halt_req",    32'(imem.req),    32'h0);
      chk("halt_pc",     32'(pc),          32'h03);
      chk("halt_opcode", 32'(opcode),      32'h7F);
      chk("halt_valid",  32'(instr_valid), 32'h0);
      do_exec(1'b1, 8'h20);
      spur = 1'b1;
      @(posedge clk); #1;
      spur = 1'b0;
      repeat (2) @(negedge clk);
      chk("halt2_halted", 32'(halted),      32'h1);
      chk("halt2_pc",     32'(pc),          32'h03);
      chk("halt2_req",    32'(imem.req),    32'h0);
      chk("halt2_valid",  32'(instr_valid), 32'h0);
      chk("halt2_opcode", 32'(opcode),      32'h7F);

      // Reset out of HALT, then again in the middle of a slow fetch.
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk_reset("rst_halt");
      @(posedge clk); #2;
      lat = 4;
      aq.push_back(8'h00);
      rst_n = 1'b1;
      @(posedge clk); @(posedge clk); #2;
      chk("midfetch_req", 32'(imem.req), 32'h1);
      rst_n = 1'b0;
      #1;
      chk_reset("rst_fetch");

      // Spurious ack on the release edge, while req is still low.
      lat = 1;
      spur = 1'b1;
      aq.push_back(8'h00); push_instr(15'h0215, 8'h00);
      @(negedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      spur = 1'b0;
      chk("spur_valid", 32'(instr_valid), 32'h0);
      chk("spur_req",   32'(imem.req),    32'h1);
      wait_valid("ispur");

      // Reset while an instruction is being issued.
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk_reset("rst_issue");
      @(posedge clk); #2;
      aq.push_back(8'h00); push_instr(15'h0215, 8'h00);
      rst_n = 1'b1;
      wait_valid("ifinal");
      @(negedge clk);
      chk("addr_queue_left",  32'(aq.size()), 32'h0);
      chk("instr_queue_left", 32'(iq.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
